// File: rtl/uart_rx_conditioner.sv
// uart_rx_conditioner
// Conditions the raw asynchronous UART serial input before it reaches the
// UART core. A reset-to-mark synchroniser feeds a persistence filter: a new
// level is accepted only after it has held for FiltLen cycles. Shorter
// excursions are rejected and counted in a saturating 8-bit counter.
// Optional break detection is enabled by defining the macro
// UART_RX_BREAK_DET_EN. A break is a space that lasts at least
// break_cycles_i cycles. Without the macro, break_o and break_pulse_o are
// tied low and break_cycles_i is ignored.
module uart_rx_conditioner #(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned FiltLen    = 4,
  parameter int unsigned CntWidth   = 20
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                sin_i,
  output logic                sin_o,
  output logic [7:0]          glitch_cnt_o,
  input  logic                glitch_clr_i,
  input  logic [CntWidth-1:0] break_cycles_i,
  output logic                break_o,
  output logic                break_pulse_o
);

  localparam int unsigned FcW = (FiltLen > 1) ? $clog2(FiltLen) : 1;
  localparam logic [FcW-1:0] FcLast = FcW'(FiltLen - 1);

  logic [SyncStages-1:0] sync_r;
  logic                  s_s;
  logic                  f_r;
  logic [FcW-1:0]        cnt_r;
  logic                  glitch_s;
  logic [7:0]            glitch_cnt_r;

  assign s_s = sync_r[SyncStages-1];

  // Synchroniser chain; idles at mark so reset release never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_r <= {SyncStages{1'b1}};
    end else begin
      sync_r <= {sync_r[SyncStages-2:0], sin_i};
    end
  end

  // A glitch is rejected when the line returns to the accepted level mid-count.
  always_comb begin
    glitch_s = 1'b0;
    if ((s_s == f_r) && (cnt_r != {FcW{1'b0}})) begin
      glitch_s = 1'b1;
    end else begin
      glitch_s = 1'b0;
    end
  end

  // Persistence filter: accept a new level after FiltLen consecutive disagreeing samples.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      f_r   <= 1'b1;
      cnt_r <= {FcW{1'b0}};
    end else if (s_s == f_r) begin
      cnt_r <= {FcW{1'b0}};
    end else if (cnt_r == FcLast) begin
      f_r   <= s_s;
      cnt_r <= {FcW{1'b0}};
    end else begin
      cnt_r <= cnt_r + FcW'(1);
    end
  end

  // Saturating rejected-glitch counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      glitch_cnt_r <= 8'd0;
    end else if (glitch_clr_i) begin
      glitch_cnt_r <= 8'd0;
    end else if (glitch_s && (glitch_cnt_r != 8'hFF)) begin
      glitch_cnt_r <= glitch_cnt_r + 8'd1;
    end else begin
      glitch_cnt_r <= glitch_cnt_r;
    end
  end

  assign sin_o        = f_r;
  assign glitch_cnt_o = glitch_cnt_r;

`ifdef UART_RX_BREAK_DET_EN
  typedef enum logic [1:0] {
    ST_MARK  = 2'b00,
    ST_SPACE = 2'b01,
    ST_BREAK = 2'b10
  } brk_state_e;

  brk_state_e          state_r;
  logic [CntWidth-1:0] bcnt_r;
  logic                break_r;
  logic                pulse_r;

  // Break FSM: time the length of a space on the filtered line and flag sustained ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_MARK;
      bcnt_r  <= {CntWidth{1'b0}};
      break_r <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      pulse_r <= 1'b0;
      case (state_r)
        ST_MARK: begin
          if (!f_r && (break_cycles_i != {CntWidth{1'b0}})) begin
            state_r <= ST_SPACE;
            bcnt_r  <= CntWidth'(1);
          end
        end
        ST_SPACE: begin
          if (f_r) begin
            state_r <= ST_MARK;
          end else if (break_cycles_i == {CntWidth{1'b0}}) begin
            state_r <= ST_MARK;
          end else if (bcnt_r >= break_cycles_i) begin
            state_r <= ST_BREAK;
            break_r <= 1'b1;
            pulse_r <= 1'b1;
          end else if (bcnt_r != {CntWidth{1'b1}}) begin
            bcnt_r <= bcnt_r + CntWidth'(1);
          end
        end
        ST_BREAK: begin
          if (f_r) begin
            state_r <= ST_MARK;
            break_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_MARK;
          break_r <= 1'b0;
        end
      endcase
    end
  end

  assign break_o       = break_r;
  assign break_pulse_o = pulse_r;
`else
  logic unused_break_cycles_s;

  assign unused_break_cycles_s = ^break_cycles_i;
  assign break_o               = 1'b0;
  assign break_pulse_o         = 1'b0;
`endif

endmodule
